// File: rtl/dr_pkg.sv
// Shared definitions for the data-register family of blocks.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dr_pkg;

  localparam int DR_WIDTH = 8;
  localparam int DR_DEPTH = 4;

  // Increment a ring pointer, wrapping from depth-1 back to 0 by explicit
  // compare so that non-power-of-two depths work unchanged.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dr_fifo_mem.sv
// WIDTH x DEPTH storage array, synchronous write, asynchronous read.
// Latency: write visible on rdata after the write edge; read is combinational.
// Backpressure: none; the controller decides when we is asserted.
module dr_fifo_mem
  import dr_pkg::*;
#(
  parameter int WIDTH = DR_WIDTH,
  parameter int DEPTH = DR_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the write port changes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dr_fifo.sv
// Buffered data register: DEPTH-entry in-order queue between D_IN and D_OUT.
// Latency: pushed word on D_OUT (EDR=1) right after its edge; EDR=0 bypasses.
// Backpressure: push dropped when FULL without POP (sets OVF); pop of empty sets UDF.
module dr_fifo
  import dr_pkg::*;
#(
  parameter  int WIDTH = DR_WIDTH,
  parameter  int DEPTH = DR_DEPTH,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDR,
  input  logic             POP,
  input  logic             EDR,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNTW-1:0]  COUNT,
  output logic             OVF,
  output logic             UDF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             ovf;
  logic             udf;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mem_we;
  logic [WIDTH-1:0] head;

  // Flags come only from registered count, never from IDR/POP.
  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same edge, so a full queue still accepts a push
  // when POP is also asserted. Empty never falls through: pop needs !empty.
  assign push = IDR & (~full | POP);
  assign pop  = POP & ~empty;

  // Reset and flush both suppress the write so the array sees no stray data.
  assign mem_we = push & rst_n & ~CLR;

  dr_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (D_IN),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer, occupancy and sticky error state; reset and flush behave alike.
  always_ff @(posedge clk) begin
    if (!rst_n || CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (pop) begin
        rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      if (push && !pop) begin
        count <= count + CNTW'(1);
      end else if (pop && !push) begin
        count <= count - CNTW'(1);
      end
      if (IDR && full && !POP) begin
        ovf <= 1'b1;
      end
      if (POP && empty) begin
        udf <= 1'b1;
      end
    end
  end

  // Output select: bypass, head entry, or zero when nothing is buffered.
  always_comb begin
    D_OUT = D_IN;
    if (EDR) begin
      D_OUT = empty ? '0 : head;
    end
  end

  assign FULL  = full;
  assign EMPTY = empty;
  assign COUNT = count;
  assign OVF   = ovf;
  assign UDF   = udf;

endmodule
